diagv2_test_sequencer: RTL and testbench
========================================

# diagv2_test_sequencer

Synthesizable test sequencer that sits downstream of the diagv2 core's `ecall` output and upstream of its reset/clock-enable inputs. It runs a regression of `TESTS` program images back-to-back with no simulator involvement. For each image it asks the image loader to fill imem/dmem, holds the core in reset, then releases it. It freezes the core on `ecall`, classifies the exit code from a7/a0, and keeps pass/fail/timeout tallies for on-board readout.

## Interface
Parameters:
- `TESTS`, 50, number of program images, indices 0..TESTS-1
- `IDX_W`, 6, width of test index; must satisfy 2^IDX_W >= TESTS
- `CNT_W`, 8, width of pass/fail counters
- `DATA_W`, `DataBusBits`, register width of a7/a0
- `RST_CYCLES`, 2, cycles `core_reset` is held with the core clocked, 1..15
- `TIMEOUT`, 65535, max RUN cycles per test; 0 disables the watchdog

Ports:
- `clk`  in  1  system clock; all state on the rising edge
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  single-cycle pulse; begins a regression; honoured only in IDLE/DONE
- `ecall`  in  1  core's decoded ECALL, valid while the ECALL is the current instruction
- `a7`  in  DATA_W  core register x17
- `a0`  in  DATA_W  core register x10
- `load_req`  out  1  request that the loader write the image for `load_idx`
- `load_idx`  out  IDX_W  image index; stable while `load_req`=1
- `load_ack`  in  1  loader completion; one-cycle pulse
- `core_reset`  out  1  active-high synchronous reset to the core
- `core_halt`  out  1  core clock-enable low; core state frozen when 1
- `passed`  out  CNT_W  tests exiting with a7=93, a0=0
- `failed`  out  CNT_W  tests exiting otherwise, including invalid ecall and timeout
- `last_code`  out  8  a0[7:0] of the most recent exit; 8'hFF on timeout
- `bad_ecall`  out  1  sticky; at least one ecall with a7≠93
- `timed_out`  out  1  sticky; at least one watchdog expiry
- `done`  out  1  regression complete

## Operation
- FSM states: IDLE, LOAD, RSTC, RUN, CHECK, DONE.
- IDLE
  - `core_reset`=1, `core_halt`=1.
  - `start` → LOAD; clears idx, `passed`, `failed`, `last_code`, `bad_ecall`, `timed_out`.
- LOAD
  - `load_req`=1, `load_idx`=idx; `core_reset`=1, `core_halt`=1.
  - `load_ack` sampled 1 → RSTC; `load_req` is 0 from the next cycle.
  - Waits indefinitely; there is no load timeout.
- RSTC
  - `core_reset`=1, `core_halt`=0, for exactly RST_CYCLES cycles, then RUN.
  - Cycle counter and watchdog are cleared on entry.
- RUN
  - `core_reset`=0.
  - Combinational `core_halt` = `ecall`, so the core freezes on the ECALL instruction in the same cycle.
  - On `ecall`=1, latch a7==93 and a0 → CHECK.
  - Watchdog counts RUN cycles. When it reaches TIMEOUT (TIMEOUT≠0) → CHECK, flagged as timeout.
  - If `ecall` and expiry coincide, the ecall wins.
- CHECK (1 cycle, `core_halt`=1)
  - Timeout: `failed`++, `timed_out`=1, `last_code`=8'hFF.
  - a7≠93: `failed`++, `bad_ecall`=1, `last_code`=a0[7:0].
  - a7=93: `last_code`=a0[7:0]; a0==0 (full DATA_W) → `passed`++, else `failed`++.
  - If idx==TESTS-1 → DONE; otherwise idx++ and → LOAD.
- DONE
  - `done`=1, `core_halt`=1, `core_reset`=0; core and counters held for readout.
  - `start` → LOAD with all counters cleared; `done` drops.
- Counters saturate at 2^CNT_W-1.
- `start` outside IDLE/DONE is ignored.
- `load_ack` outside LOAD is ignored.

## Timing
- Reset (async, `reset`=0) forces:
  - state IDLE, idx 0;
  - `core_reset`=1, `core_halt`=1, `load_req`=0, `load_idx`=0;
  - `passed`=0, `failed`=0, `last_code`=0;
  - `bad_ecall`=0, `timed_out`=0, `done`=0.
- Reset mid-run aborts immediately, and the core is reset on the following cycle edge.
- All outputs are registered except `core_halt` in RUN.
- `start` at edge T → `load_req`=1 from T+1.
- `load_ack` at edge L → `core_reset` held through L+RST_CYCLES; core runs from L+RST_CYCLES+1.
- `ecall` at edge E:
  - `core_halt`=1 combinationally from E-ε;
  - CHECK in E+1..E+2;
  - counters visible after edge E+2;
  - next `load_req`=1 from E+2, or `done`=1 from E+2 on the last test.
- Per-test overhead, excluding loader time: RST_CYCLES+3 cycles.

## Test plan
- Two-test run with TESTS=2, RST_CYCLES=2. Loader acks after 5 cycles; core model issues ecall a7=93, a0=0 after 20 RUN cycles, twice → `passed`=2, `failed`=0, `done`=1, `load_idx` sequence 0,1, `core_reset` high exactly 2 clocked cycles per test.
- Nonzero exit: ecall a7=93, a0=3 → `failed`=1, `last_code`=3; next `load_req` two cycles after the ecall edge.
- Invalid ecall: a7=64 → `bad_ecall`=1, `failed`=1, and the sequencer advances to the next index.
- Watchdog with TIMEOUT=10 and no ecall → CHECK after 10 RUN cycles, `timed_out`=1, `last_code`=8'hFF.
- Same setup with ecall asserted on the expiry cycle → counted as ecall: `timed_out`=0, `passed`=1.
- Async reset asserted mid-RUN with test index 1 → all outputs at reset values within the same cycle. `start` issued in RUN is ignored. `start` in DONE restarts from index 0 with counters cleared.

Source files
------------

// File: rtl/diagv2_test_sequencer_if.sv
// Loader handshake and core control/observation bundle between the test
// sequencer (master) and the loader/core side (slave).
interface diagv2_test_sequencer_if #(
    parameter int IDX_W  = 6,
    parameter int DATA_W = 32
);
    logic              load_req;
    logic [IDX_W-1:0]  load_idx;
    logic              load_ack;
    logic              ecall;
    logic [DATA_W-1:0] a7;
    logic [DATA_W-1:0] a0;
    logic              core_reset;
    logic              core_halt;

    modport master (
        output load_req, load_idx, core_reset, core_halt,
        input  load_ack, ecall, a7, a0
    );

    modport slave (
        input  load_req, load_idx, core_reset, core_halt,
        output load_ack, ecall, a7, a0
    );
endinterface

// File: rtl/diagv2_test_sequencer.sv
// On-board regression sequencer: loads each program image, resets and runs the
// core, freezes it on ecall and tallies pass/fail/timeout results.
module diagv2_test_sequencer #(
    parameter int          TESTS      = 50,
    parameter int          IDX_W      = 6,
    parameter int          CNT_W      = 8,
    parameter int          DATA_W     = 32,   // core data bus width
    parameter int          RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    diagv2_test_sequencer_if.master bus,
    output logic [CNT_W-1:0]       passed,
    output logic [CNT_W-1:0]       failed,
    output logic [7:0]             last_code,
    output logic                   bad_ecall,
    output logic                   timed_out,
    output logic                   done
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST   = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [3:0]       RST_LAST  = 4'(RST_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(TESTS - 1);
    localparam logic [DATA_W-1:0] EXIT_NR  = DATA_W'(93);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RSTC,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [3:0]        rst_cnt_reg;
    logic [WD_W-1:0]   wd_reg;
    logic              load_req_reg;
    logic              core_reset_reg;
    logic              core_halt_reg;
    logic [CNT_W-1:0]  passed_reg;
    logic [CNT_W-1:0]  failed_reg;
    logic [7:0]        last_code_reg;
    logic              bad_ecall_reg;
    logic              timed_out_reg;
    logic              done_reg;
    logic              chk_timeout_reg;
    logic              chk_a7_ok_reg;
    logic              chk_a0_zero_reg;
    logic [7:0]        chk_code_reg;
    logic              wd_expired;

    // TIMEOUT of zero removes the watchdog entirely
    generate
        if (TIMEOUT == 0) begin : g_no_wd
            assign wd_expired = 1'b0;
        end else begin : g_wd
            assign wd_expired = (wd_reg == WD_LAST);
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= '0;
            rst_cnt_reg     <= '0;
            wd_reg          <= '0;
            load_req_reg    <= 1'b0;
            core_reset_reg  <= 1'b1;
            core_halt_reg   <= 1'b1;
            passed_reg      <= '0;
            failed_reg      <= '0;
            last_code_reg   <= '0;
            bad_ecall_reg   <= 1'b0;
            timed_out_reg   <= 1'b0;
            done_reg        <= 1'b0;
            chk_timeout_reg <= 1'b0;
            chk_a7_ok_reg   <= 1'b0;
            chk_a0_zero_reg <= 1'b0;
            chk_code_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg      <= ST_LOAD;
                        idx_reg        <= '0;
                        load_req_reg   <= 1'b1;
                        core_reset_reg <= 1'b1;
                        core_halt_reg  <= 1'b1;
                        passed_reg     <= '0;
                        failed_reg     <= '0;
                        last_code_reg  <= '0;
                        bad_ecall_reg  <= 1'b0;
                        timed_out_reg  <= 1'b0;
                        done_reg       <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (bus.load_ack) begin
                        state_reg     <= ST_RSTC;
                        load_req_reg  <= 1'b0;
                        core_halt_reg <= 1'b0;
                        rst_cnt_reg   <= '0;
                        wd_reg        <= '0;
                    end
                end

                // core is clocked with reset asserted for RST_CYCLES edges
                ST_RSTC: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        state_reg      <= ST_RUN;
                        core_reset_reg <= 1'b0;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + 4'd1;
                    end
                end

                ST_RUN: begin
                    if (bus.ecall) begin
                        state_reg       <= ST_CHECK;
                        core_halt_reg   <= 1'b1;
                        chk_timeout_reg <= 1'b0;
                        chk_a7_ok_reg   <= (bus.a7 == EXIT_NR);
                        chk_a0_zero_reg <= (bus.a0 == '0);
                        chk_code_reg    <= bus.a0[7:0];
                    end else if (wd_expired) begin
                        state_reg       <= ST_CHECK;
                        core_halt_reg   <= 1'b1;
                        chk_timeout_reg <= 1'b1;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
                end

                ST_CHECK: begin
                    if (chk_timeout_reg) begin
                        failed_reg    <= sat_inc(failed_reg);
                        timed_out_reg <= 1'b1;
                        last_code_reg <= 8'hFF;
                    end else if (!chk_a7_ok_reg) begin
                        failed_reg    <= sat_inc(failed_reg);
                        bad_ecall_reg <= 1'b1;
                        last_code_reg <= chk_code_reg;
                    end else begin
                        last_code_reg <= chk_code_reg;
                        if (chk_a0_zero_reg) begin
                            passed_reg <= sat_inc(passed_reg);
                        end else begin
                            failed_reg <= sat_inc(failed_reg);
                        end
                    end

                    if (idx_reg == IDX_LAST) begin
                        state_reg      <= ST_DONE;
                        done_reg       <= 1'b1;
                        core_reset_reg <= 1'b0;
                    end else begin
                        state_reg      <= ST_LOAD;
                        idx_reg        <= idx_reg + IDX_W'(1);
                        load_req_reg   <= 1'b1;
                        core_reset_reg <= 1'b1;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // halt follows ecall combinationally in RUN so the ECALL itself never retires
    assign bus.core_halt  = (state_reg == ST_RUN) ? bus.ecall : core_halt_reg;
    assign bus.core_reset = core_reset_reg;
    assign bus.load_req   = load_req_reg;
    assign bus.load_idx   = idx_reg;

    assign passed    = passed_reg;
    assign failed    = failed_reg;
    assign last_code = last_code_reg;
    assign bad_ecall = bad_ecall_reg;
    assign timed_out = timed_out_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_diagv2_test_sequencer.sv
// Bench for diagv2_test_sequencer: acts as image loader and core, compares the
// tallies against an outcome model derived from each test's planned exit.
`timescale 1ns/1ps
module tb_diagv2_test_sequencer;

    localparam int TESTS      = 6;
    localparam int IDX_W      = 3;
    localparam int CNT_W      = 2;
    localparam int DATA_W     = 32;
    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 24;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] passed;
    logic [CNT_W-1:0] failed;
    logic [7:0]       last_code;
    logic             bad_ecall;
    logic             timed_out;
    logic             done;

    diagv2_test_sequencer_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

    diagv2_test_sequencer #(
        .TESTS(TESTS), .IDX_W(IDX_W), .CNT_W(CNT_W), .DATA_W(DATA_W),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(bus),
        .passed(passed),
        .failed(failed),
        .last_code(last_code),
        .bad_ecall(bad_ecall),
        .timed_out(timed_out),
        .done(done)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        int          ack_dly;
        int          n;        // RUN cycle carrying the ecall; 0 = never
        logic [31:0] a7;
        logic [31:0] a0;
        logic        poke;     // stray start/load_ack during RUN
    } plan_t;

    plan_t plan [TESTS];

    int         m_pass;
    int         m_fail;
    logic [7:0] m_code;
    logic       m_bad;
    logic       m_tmo;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic check_tallies(input string pfx);
        check_val({pfx, "_passed"},    32'(passed),    32'(sat(m_pass)));
        check_val({pfx, "_failed"},    32'(failed),    32'(sat(m_fail)));
        check_val({pfx, "_last_code"}, 32'(last_code), 32'(m_code));
        check_val({pfx, "_bad_ecall"}, 32'(bad_ecall), 32'(m_bad));
        check_val({pfx, "_timed_out"}, 32'(timed_out), 32'(m_tmo));
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_core_reset"}, 32'(bus.core_reset), 32'd1);
        check_val({pfx, "_core_halt"},  32'(bus.core_halt),  32'd1);
        check_val({pfx, "_load_req"},   32'(bus.load_req),   32'd0);
        check_val({pfx, "_load_idx"},   32'(bus.load_idx),   32'd0);
        check_val({pfx, "_done"},       32'(done),           32'd0);
        m_pass = 0; m_fail = 0; m_code = 8'h00; m_bad = 1'b0; m_tmo = 1'b0;
        check_tallies(pfx);
    endtask

    function automatic plan_t rand_plan();
        plan_t p;
        int    sel;
        p.ack_dly = int'($urandom_range(0, 5));
        p.n       = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 6));
        p.a7      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : 32'd93;
        sel       = int'($urandom_range(0, 3));
        p.a0      = (sel < 2) ? 32'd0 : (sel == 2) ? 32'($urandom_range(1, 255)) : ($urandom << 8);
        p.poke    = ($urandom_range(0, 2) == 0);
        return p;
    endfunction

    // Expected result of one test from its planned exit
    task automatic model_outcome(input plan_t p);
        if (p.n == 0 || p.n > TIMEOUT) begin
            m_fail++; m_tmo = 1'b1; m_code = 8'hFF;
        end else if (p.a7 != 32'd93) begin
            m_fail++; m_bad = 1'b1; m_code = p.a0[7:0];
        end else begin
            m_code = p.a0[7:0];
            if (p.a0 == 32'd0) m_pass++;
            else               m_fail++;
        end
    endtask

    task automatic run_regression(input int abort_at);
        int  rc;
        int  last_k;
        bit  tmo;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pass = 0; m_fail = 0; m_code = 8'h00; m_bad = 1'b0; m_tmo = 1'b0;
        check_val("start_done_clr", 32'(done), 32'd0);
        check_tallies("start");
        for (int t = 0; t < TESTS; t++) begin
            check_val("load_req", 32'(bus.load_req), 32'd1);
            check_val("load_idx", 32'(bus.load_idx), 32'(t));
            check_val("load_core_reset", 32'(bus.core_reset), 32'd1);
            check_val("load_core_halt", 32'(bus.core_halt), 32'd1);
            repeat (plan[t].ack_dly) tick();
            check_val("load_req_hold", 32'(bus.load_req), 32'd1);
            bus.load_ack = 1'b1;
            tick();
            bus.load_ack = 1'b0;
            check_val("ack_req_drop", 32'(bus.load_req), 32'd0);
            rc = 0;
            while (bus.core_reset && !bus.core_halt && rc < 20) begin
                rc++;
                tick();
            end
            check_val("rst_cycles", 32'(rc), 32'(RST_CYCLES));
            check_val("run_core_reset", 32'(bus.core_reset), 32'd0);

            tmo    = (plan[t].n == 0 || plan[t].n > TIMEOUT);
            last_k = tmo ? TIMEOUT : plan[t].n;
            for (int k = 1; k < last_k; k++) begin
                if (k == 1 && plan[t].poke) begin
                    start = 1'b1;
                    bus.load_ack = 1'b1;
                end
                if (abort_at == t && k == 2) begin
                    #2;
                    reset = 1'b0;
                    #1;
                    check_reset_state("abort");
                    tick();
                    tick();
                    reset = 1'b1;
                    $display("[TB] test %0d aborted by reset in RUN", t);
                    return;
                end
                tick();
                start = 1'b0;
                bus.load_ack = 1'b0;
            end
            check_val("run_not_halted", 32'(bus.core_halt), 32'd0);
            if (!tmo) begin
                bus.ecall = 1'b1;
                bus.a7    = plan[t].a7;
                bus.a0    = plan[t].a0;
                #1;
                check_val("ecall_halt_comb", 32'(bus.core_halt), 32'd1);
            end
            tick();
            bus.ecall = 1'b0;
            bus.a7    = $urandom;
            bus.a0    = $urandom;
            check_val("check_halt", 32'(bus.core_halt), 32'd1);
            check_val("check_no_req", 32'(bus.load_req), 32'd0);
            tick();
            model_outcome(plan[t]);
            check_tallies("post_test");
            if (t == TESTS - 1) begin
                check_val("done", 32'(done), 32'd1);
                check_val("done_halt", 32'(bus.core_halt), 32'd1);
                check_val("done_core_reset", 32'(bus.core_reset), 32'd0);
                check_val("done_no_req", 32'(bus.load_req), 32'd0);
            end else begin
                check_val("not_done", 32'(done), 32'd0);
            end
            $display("[TB] test %0d n=%0d a7=%0d a0=0x%0h -> passed=%0d failed=%0d code=0x%0h",
                     t, plan[t].n, plan[t].a7, plan[t].a0, passed, failed, last_code);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.load_ack = 1'b0;
        bus.ecall    = 1'b0;
        bus.a7       = '0;
        bus.a0       = '0;
        repeat (3) tick();
        check_reset_state("reset");
        reset = 1'b1;
        tick();
        bus.load_ack = 1'b1;
        tick();
        bus.load_ack = 1'b0;
        check_val("idle_ack_ignored", 32'(bus.load_req), 32'd0);

        // directed: pass, pass, nonzero exit, bad ecall, timeout, ecall on expiry
        plan[0] = '{ack_dly: 5, n: 20,      a7: 32'd93, a0: 32'd0, poke: 1'b0};
        plan[1] = '{ack_dly: 5, n: 20,      a7: 32'd93, a0: 32'd0, poke: 1'b1};
        plan[2] = '{ack_dly: 1, n: 7,       a7: 32'd93, a0: 32'd3, poke: 1'b0};
        plan[3] = '{ack_dly: 0, n: 4,       a7: 32'd64, a0: 32'd5, poke: 1'b0};
        plan[4] = '{ack_dly: 2, n: 0,       a7: 32'd93, a0: 32'd0, poke: 1'b0};
        plan[5] = '{ack_dly: 3, n: TIMEOUT, a7: 32'd93, a0: 32'd0, poke: 1'b0};
        run_regression(-1);

        // restart from DONE with random exits
        for (int r = 0; r < 3; r++) begin
            for (int t = 0; t < TESTS; t++) plan[t] = rand_plan();
            run_regression(-1);
        end

        // abort mid-RUN on index 1, then a fresh run from IDLE
        for (int t = 0; t < TESTS; t++) plan[t] = rand_plan();
        plan[1].n = 20;
        run_regression(1);
        for (int t = 0; t < TESTS; t++) plan[t] = rand_plan();
        run_regression(-1);

        // every test passes: counter must saturate
        for (int t = 0; t < TESTS; t++) begin
            plan[t] = rand_plan();
            plan[t].n  = int'($urandom_range(1, TIMEOUT));
            plan[t].a7 = 32'd93;
            plan[t].a0 = 32'd0;
        end
        run_regression(-1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
